// File: rtl/mcu_pio_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pio_pkg
// Shared definitions for the interrupt-capable input PIO (mcu_pio_in_irq).
//
// Contents:
//   pio_addr_e : Avalon-MM word addresses of the register map
//                (DATA, reserved, IRQ_MASK, EDGE_CAPTURE).
//   EDGE_*     : encodings for the EDGE_TYPE parameter
//                (0 rising, 1 falling, 2 any).
//   clog2()    : ceiling log2, used to size counters from parameters.
// -----------------------------------------------------------------------------
package mcu_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } pio_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Ceiling log2: number of bits needed to encode 'value' distinct states.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mcu_pio_debounce.sv
// -----------------------------------------------------------------------------
// mcu_pio_debounce
// Single-bit input conditioner: a SYNC_STAGES-deep synchroniser followed,
// when MCU_PIO_DEBOUNCE_EN is defined, by a stability filter that only lets
// the output follow the synchronised input after it has differed from the
// current output for DEBOUNCE_CYCLES consecutive cycles. Without the macro
// the output is the last synchroniser stage and no counter exists.
//
// Optional feature macro: MCU_PIO_DEBOUNCE_EN
//
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   din   in  asynchronous pin input
//   dout  out synchronised (and optionally debounced) value
// -----------------------------------------------------------------------------
module mcu_pio_debounce
  import mcu_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef MCU_PIO_DEBOUNCE_EN
  localparam int unsigned CNT_W_RAW = clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             filt;

  // The counter only advances while the input disagrees with the filtered
  // value; any return to agreement restarts it, so a pulse shorter than
  // DEBOUNCE_CYCLES never reaches the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_out == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync_out;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign dout = filt;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign dout = sync_out;
`endif

endmodule

// File: rtl/mcu_pio_in_irq.sv
// -----------------------------------------------------------------------------
// mcu_pio_in_irq
// Avalon-MM input PIO slave with per-bit edge capture and a maskable level
// interrupt. Each pin goes through mcu_pio_debounce (synchroniser plus the
// optional debounce filter), then an edge detector feeds a write-1-to-clear
// capture register. irq is the OR of captured edges that are unmasked.
//
// Optional feature macro: MCU_PIO_DEBOUNCE_EN (enables per-bit debounce).
//
// Register map (word addresses):
//   0 DATA          RO  filtered synchronised input
//   1 reserved      reads 0, writes ignored
//   2 IRQ_MASK      RW  WIDTH bits
//   3 EDGE_CAPTURE  R / write 1 to clear per bit
//
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   address    in  [1:0] register word address
//   chipselect in  slave select (writes only)
//   write_n    in  active-low write strobe
//   writedata  in  [31:0] write data (bits >= WIDTH ignored)
//   readdata   out [31:0] registered read data, 1-cycle latency
//   in_port    in  [WIDTH-1:0] asynchronous pin inputs
//   irq        out level interrupt, active-high
// -----------------------------------------------------------------------------
module mcu_pio_in_irq
  import mcu_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter logic [31:0] RESET_IRQ_MASK  = '0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned         WARM_W    = clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0]   WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  filt;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  det;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  edge_capture;
  logic [WIDTH-1:0]  irq_mask;
  logic [WARM_W-1:0] warm_cnt;
  logic              armed;
  logic              wr;
  logic              unused_wdata;

  // Upper writedata bits beyond WIDTH are intentionally dropped.
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Per-bit input conditioning
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mcu_pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .dout  (filt[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  always_comb begin
    det = filt & ~prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      det = ~filt & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      det = filt ^ prev;
    end
  end

  // Warm-up: the synchroniser and prev start at 0, so a pin already high at
  // reset would look like a rising edge. Capture stays disarmed until the
  // pipeline has had SYNC_STAGES+1 cycles to fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (!armed) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign armed = (warm_cnt == WARM_DONE);

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign wr  = chipselect & ~write_n;
  assign clr = (wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= RESET_IRQ_MASK[WIDTH-1:0];
    end else if (wr && (address == ADDR_IRQ_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Set has priority over a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr) | (armed ? det : '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered every cycle from the current address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:     readdata <= 32'(filt);
        ADDR_IRQ_MASK: readdata <= 32'(irq_mask);
        ADDR_EDGE_CAP: readdata <= 32'(edge_capture);
        default:       readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
